// File: rtl/mem_map_pkg.sv
// Shared definitions for the 4 KiB-word memory map: bank codes, FSM states,
// default widths and the bank chip-select decode.
package mem_map_pkg;

    localparam int MEM_AW = 12;
    localparam int MEM_DW = 16;

    localparam logic [1:0] BANK_ROM  = 2'b00;
    localparam logic [1:0] BANK_RAM1 = 2'b01;
    localparam logic [1:0] BANK_RAM2 = 2'b10;
    localparam logic [1:0] BANK_RAM3 = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ACCESS  = 2'b01,
        ST_CAPTURE = 2'b10,
        ST_DONE    = 2'b11
    } arb_state_t;

    // Returns {cs_rom, cs_ram[2:0]}, always one-hot.
    function automatic logic [3:0] bank_decode(input logic [1:0] bank);
        logic [3:0] sel;
        case (bank)
            BANK_ROM:  sel = 4'b1000;
            BANK_RAM1: sel = 4'b0001;
            BANK_RAM2: sel = 4'b0010;
            BANK_RAM3: sel = 4'b0100;
            default:   sel = 4'b0000;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the last-grant register only moves when the
// sequencer enables arbitration and someone actually requests.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    logic last_r;

    // Tie goes to the port that was not granted last.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_r ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    // Remember which port won the most recent arbitration.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_r <= 1'b1;
        end else if (en && (|req)) begin
            last_r <= grant[1];
        end else begin
            last_r <= last_r;
        end
    end

endmodule

// File: rtl/mem_bank_arbiter.sv
// Two-requester arbiter/sequencer for the ROM + 3xSRAM map: grants a port,
// drives one bank for a cycle, captures synchronous read data and acks.
module mem_bank_arbiter
    import mem_map_pkg::*;
#(
    parameter int AW = MEM_AW,
    parameter int DW = MEM_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    req,
    input  logic [1:0]    we,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic [1:0]    ack,
    output logic [DW-1:0] rdata,
    output logic          err,
    output logic [9:0]    mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          cs_rom,
    output logic [2:0]    cs_ram,
    output logic          mem_wr,
    input  logic [DW-1:0] rom_q,
    input  logic [DW-1:0] ram1_q,
    input  logic [DW-1:0] ram2_q,
    input  logic [DW-1:0] ram3_q
);

    arb_state_t    state_r;
    logic [1:0]    grant_s;
    logic          port_r;
    logic          we_r;
    logic [1:0]    bank_r;
    logic          rom_wr_r;
    logic          sel_we_s;
    logic [AW-1:0] sel_addr_s;
    logic [DW-1:0] sel_wdata_s;
    logic [1:0]    sel_bank_s;
    logic [DW-1:0] bank_q_s;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .en    (state_r == ST_IDLE),
        .req   (req),
        .grant (grant_s)
    );

    // Steer the winning port's request fields toward the latch.
    always_comb begin
        if (grant_s[1]) begin
            sel_we_s    = we[1];
            sel_addr_s  = addr1;
            sel_wdata_s = wdata1;
        end else begin
            sel_we_s    = we[0];
            sel_addr_s  = addr0;
            sel_wdata_s = wdata0;
        end
        sel_bank_s = sel_addr_s[AW-1 -: 2];
    end

    // Read-data mux keyed by the latched bank.
    always_comb begin
        case (bank_r)
            BANK_ROM:  bank_q_s = rom_q;
            BANK_RAM1: bank_q_s = ram1_q;
            BANK_RAM2: bank_q_s = ram2_q;
            BANK_RAM3: bank_q_s = ram3_q;
            default:   bank_q_s = rom_q;
        endcase
    end

    // Sequencer: IDLE -> ACCESS -> CAPTURE -> DONE, all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            port_r    <= 1'b0;
            we_r      <= 1'b0;
            bank_r    <= 2'b00;
            rom_wr_r  <= 1'b0;
            ack       <= 2'b00;
            err       <= 1'b0;
            rdata     <= {DW{1'b0}};
            mem_addr  <= 10'd0;
            mem_wdata <= {DW{1'b0}};
            cs_rom    <= 1'b0;
            cs_ram    <= 3'b000;
            mem_wr    <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (|grant_s) begin
                        port_r    <= grant_s[1];
                        we_r      <= sel_we_s;
                        bank_r    <= sel_bank_s;
                        rom_wr_r  <= sel_we_s && (sel_bank_s == BANK_ROM);
                        mem_addr  <= sel_addr_s[9:0];
                        mem_wdata <= sel_wdata_s;
                        // The ROM is never selected for a write.
                        if (sel_we_s && (sel_bank_s == BANK_ROM)) begin
                            {cs_rom, cs_ram} <= 4'b0000;
                            mem_wr           <= 1'b1;
                        end else begin
                            {cs_rom, cs_ram} <= bank_decode(sel_bank_s);
                            mem_wr           <= ~sel_we_s;
                        end
                        state_r <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    {cs_rom, cs_ram} <= 4'b0000;
                    mem_wr           <= 1'b1;
                    state_r          <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    if (!we_r) begin
                        rdata <= bank_q_s;
                    end
                    ack     <= port_r ? 2'b10 : 2'b01;
                    err     <= rom_wr_r;
                    state_r <= ST_DONE;
                end
                ST_DONE: begin
                    ack     <= 2'b00;
                    err     <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_bank_arbiter.md
# mem_bank_arbiter

Two-requester arbiter and sequencer for the 4 KiB-word memory map: bank 0 is the 1 KiB ROM, banks 1–3 are three 1 KiB SRAMs. It sits between the requesters (port 0: display/word fetch engine; port 1: loader/CPU side) and the ROM/SRAM instances. It decodes addr[11:10] into one-hot chip selects, drives the shared 10-bit bank address, write-data and write strobe, and captures read data from the selected bank. It returns an ack pulse with data or an error flag.

## Interface
Parameters:
- AW, 12, full word address width; top two bits select the bank
- DW, 16, data word width

Ports:
- clk  in  1  single clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- req  in  2  per-port request, level; held until that port's ack
- we  in  2  per-port write enable (1 = write), sampled with req
- addr0, addr1  in  AW  per-port word address
- wdata0, wdata1  in  DW  per-port write data
- ack  out  2  one-cycle completion pulse, one bit per port
- rdata  out  DW  read data, valid in the ack cycle, held until the next ack
- err  out  1  high in the ack cycle when a write targeted ROM (bank 0)
- mem_addr  out  10  shared bank address = granted addr[9:0]
- mem_wdata  out  DW  shared write data
- cs_rom  out  1  ROM chip select, active-high
- cs_ram  out  3  SRAM chip selects, one-hot; bit k selects bank k+1
- mem_wr  out  1  1 = read (idle level), 0 = write
- rom_q, ram1_q, ram2_q, ram3_q  in  DW  bank read data; synchronous, valid one cycle after the select

## Operation
- FSM states: IDLE, ACCESS, CAPTURE, DONE.
- IDLE: if any req is set, grant one port, latch its we, addr and wdata, and go to ACCESS. If no req is set, stay in IDLE.
- Arbitration is round-robin. A last-grant register (reset value 1) decides ties: when both ports request, the port not granted last wins. A single requester always wins.
- ACCESS: assert exactly one select from the latched addr[11:10] (00→cs_rom, 01→cs_ram[0], 10→cs_ram[1], 11→cs_ram[2]). Drive mem_addr and mem_wdata. Drive mem_wr=0 only for a write to banks 1–3.
- A write to bank 0 asserts no select, leaves mem_wr=1, and sets the error flag. The ROM is never written.
- CAPTURE: deassert all selects, restore mem_wr=1. For a read, load rdata from the bank-data mux of the latched bank. For a write, leave rdata unchanged.
- DONE: pulse ack[granted]=1 and drive err, then return to IDLE. The winner's req is ignored in this cycle.
- A requester must drop req in the cycle after its ack or it is served again. The other port then wins any tie.
- Changes to a port's inputs while it is granted have no effect, because all inputs are latched in IDLE.

## Timing
- Reset values: ack=0, err=0, rdata=0, cs_rom=0, cs_ram=000, mem_wr=1, mem_addr=0, mem_wdata=0, state=IDLE, last-grant=1.
- Latency: req sampled in cycle t gives selects in t+1, capture in t+2, and ack in t+3. Fixed at 3 cycles for reads and writes.
- Throughput is one access per 4 cycles. Back-to-back service is possible, with IDLE lasting one cycle.
- Outputs are registered; no combinational path runs from req to any output.
- At most one select is high in any cycle; all selects are low outside ACCESS.
- Reset mid-operation (any state) aborts the access: no ack is issued, and all outputs take their reset values in the next cycle.

## Structure
- Shared package mem_map_pkg holds:
  - bank codes BANK_ROM=2'b00, BANK_RAM1=2'b01, BANK_RAM2=2'b10, BANK_RAM3=2'b11
  - the FSM state typedef
  - AW and DW defaults
  - the bank-decode function (addr[11:10] → {cs_rom, cs_ram})
- One sub-module, rr_arb2: a 2-way round-robin arbiter with a last-grant register, taking an enable input from the FSM.
- The FSM, the input latch and the read-data mux live in the top module.

## Test plan
- Read ROM: port 0 reads addr 0x005 with rom_q=16'h3A5C -> cs_rom high one cycle at t+1, mem_addr=0x005, ack=01 at t+3, rdata=16'h3A5C, err=0.
- Write then read RAM3: port 1 writes 16'hBEEF to 0xC10, then reads 0xC10 -> on the write, cs_ram=100 and mem_wr=0 for one cycle with mem_addr=0x010. On the read, rdata=16'hBEEF.
- ROM write rejected: port 1 writes to 0x123 -> no select is ever asserted, mem_wr stays 1, ack=10 with err=1, and rdata is unchanged.
- Contention: both ports hold req continuously after reset -> grants alternate 0,1,0,1, with acks every 4 cycles and port 0 first.
- Reset in ACCESS: assert rst while cs_ram=010 -> the next cycle has all selects 0 and mem_wr=1, and no ack follows. A request after reset completes normally in 3 cycles.
- Bank decode sweep: read 0x000, 0x400, 0x800 and 0xC00 -> exactly one of cs_rom, cs_ram[0], cs_ram[1], cs_ram[2] is high for each, and rdata matches that bank's data input.
